// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges single-cycle ALU results and FIFO-buffered load results onto
// the register file write port. Optional macro WB_ZERO_PROTECT_EN suppresses we3 for address 0.
module wb_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 3,
  parameter int unsigned DATA_W       = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [4:0]              alu_wa,
  input  logic [DATA_W-1:0]       alu_wd,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic [4:0]              ld_wa,
  input  logic [DATA_W-1:0]       ld_wd,
  output logic                    we3,
  output logic [4:0]              wa3,
  output logic [DATA_W-1:0]       wd3,
  output logic [$clog2(DEPTH):0]  ld_pending
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned AW    = 5;

  logic [AW-1:0]     mem_wa [DEPTH];
  logic [DATA_W-1:0] mem_wd [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_nxt;
  logic [SC_W-1:0]   starve_cnt, starve_nxt;
  logic              empty, stall_alu, push, pop, alu_grant, any_grant, grant_we;
  logic [AW-1:0]     grant_wa;
  logic [DATA_W-1:0] grant_wd;

  assign ld_pending = count;

  // Grant selection, occupancy and starvation bookkeeping
  always_comb begin
    empty      = (count == '0);
    stall_alu  = (starve_cnt == SC_W'(STARVE_LIMIT)) && !empty;
    alu_ready  = !stall_alu;
    alu_grant  = alu_valid && !stall_alu;
    pop        = !alu_grant && !empty;
    push       = ld_valid && ld_ready;
    any_grant  = alu_grant || pop;
    grant_wa   = alu_grant ? alu_wa : mem_wa[rd_ptr];
    grant_wd   = alu_grant ? alu_wd : mem_wd[rd_ptr];
`ifdef WB_ZERO_PROTECT_EN
    grant_we   = any_grant && (grant_wa != '0);
`else
    grant_we   = any_grant;
`endif

    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase

    starve_nxt = starve_cnt;
    if (pop || empty)
      starve_nxt = '0;
    else if (alu_grant && (starve_cnt != SC_W'(STARVE_LIMIT)))
      starve_nxt = starve_cnt + SC_W'(1);
  end

  // Control state and registered write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      ld_ready   <= 1'b0;
      we3        <= 1'b0;
      wa3        <= '0;
      wd3        <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count      <= count_nxt;
      starve_cnt <= starve_nxt;
      ld_ready   <= (count_nxt != CNT_W'(DEPTH));
      we3        <= grant_we;
      if (any_grant) begin
        wa3 <= grant_wa;
        wd3 <= grant_wd;
      end
    end
  end

  // Payload storage needs no reset; occupancy guards every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem_wa[wr_ptr] <= ld_wa;
      mem_wd[wr_ptr] <= ld_wd;
    end
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-back arbiter directly upstream of the register file; sole driver of its write port (we3/wa3/wd3).
- Merges two result sources:
  - single-cycle ALU results;
  - variable-latency load results, buffered in a small FIFO.
- Registers the winning write on posedge clk, so we3/wa3/wd3 are stable for the register file's negedge write.
- Starvation counter throttles the ALU so queued loads always drain.

Parameters:
DEPTH, 4, load FIFO entries; power of 2, >= 2
STARVE_LIMIT, 3, consecutive ALU grants allowed while FIFO non-empty before the ALU is stalled; >= 1
DATA_W, 32, result data width

Ports:
clk  in  1  clock, all state updated on rising edge
rst  in  1  asynchronous reset, active-low (asserted when 0)
alu_valid  in  1  ALU result present this cycle
alu_ready  out  1  ALU result accepted this cycle
alu_wa  in  5  ALU destination register
alu_wd  in  DATA_W  ALU result data
ld_valid  in  1  load result present
ld_ready  out  1  load FIFO can accept (registered)
ld_wa  in  5  load destination register
ld_wd  in  DATA_W  load data
we3  out  1  register file write enable
wa3  out  5  register file write address
wd3  out  DATA_W  register file write data
ld_pending  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst=0, async):
  - we3=0, wa3=0, wd3=0; FIFO empty, ld_pending=0, starve_cnt=0.
  - ld_ready=0 while rst=0; ld_ready=1 on the first edge after release.
  - Reset mid-operation discards all queued loads; the regfile sees no further write.
- FIFO push: on ld_valid && ld_ready.
  - ld_ready = !full, registered from next-cycle occupancy.
  - When full, no push occurs even if a pop happens the same cycle.
  - Data with ld_valid=1 && ld_ready=0 is held by the source; it is not dropped here.
- Grant, evaluated each cycle:
  - stall_alu = (starve_cnt == STARVE_LIMIT) && !empty.
  - alu_ready = !stall_alu (combinational).
  - If alu_valid && alu_ready: grant ALU.
  - Else if !empty: grant FIFO head (pop).
  - Else: no grant.
- Output register (posedge):
  - On a grant: we3<=1, wa3/wd3 <= granted address/data.
  - With no grant: we3<=0 and wa3/wd3 hold their previous values.
- Starvation counter:
  - ALU granted while FIFO non-empty: starve_cnt+1, saturating at STARVE_LIMIT.
  - FIFO popped: starve_cnt=0.
  - FIFO empty: starve_cnt=0.
- Latency:
  - ALU result: we3 asserted 1 cycle after acceptance.
  - Load into empty FIFO with no ALU traffic: pushed in cycle T, popped T+1, we3 asserted at T+2.
- Ordering and data rules:
  - Writes reach the regfile in grant order; no coalescing or reordering.
  - Same-address ALU/load conflicts are the hazard unit's responsibility.
- Pointers: log2(DEPTH) bits, natural wrap. Full/empty are derived from occupancy, never from pointer equality alone.
- Simultaneous push and pop in the same cycle: occupancy unchanged; head data is correct across wrap-around.

Optional Feature:
- Macro: WB_ZERO_PROTECT_EN.
- Defined:
  - Any granted write with address 0 still consumes its slot/cycle (FIFO pop, alu_ready handshake, starvation accounting) but drives we3=0.
  - Load pushes to address 0 are still enqueued.
- Undefined: writes to address 0 pass through like any other address.

Test Plan:
- Reset release, idle inputs -> we3=0, wa3=0, wd3=0, ld_pending=0; ld_ready=0 during reset, 1 one cycle after release.
- ALU result (wa=5, wd=0xDEADBEEF) at cycle T, FIFO empty -> alu_ready=1 at T; we3=1, wa3=5, wd3=0xDEADBEEF at T+1; we3=0 at T+2.
- Load (wa=7, wd=0x1234) at T, no ALU traffic -> ld_pending=1 at T+1; we3=1, wa3=7, wd3=0x1234 at T+2.
- alu_valid held high continuously plus one load (STARVE_LIMIT=3) -> 3 ALU writes, then alu_ready=0 for exactly one cycle, load written next, then ALU resumes.
- 5 loads pushed with the ALU saturating (DEPTH=4) -> ld_ready=0 after 4 pushes, 5th held by source; after draining, all 5 are written in order, with pointers wrapping correctly.
- With WB_ZERO_PROTECT_EN: ALU write to address 0 -> alu_ready=1, we3 stays 0. Without it -> we3=1, wa3=0.
